// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard receiver.
// Holds the scan-code constants, the frame length and the tracker state type.
// Imported by ps2_fifo and ps2_kbd_rx.
package ps2_pkg;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;
  localparam int         FRAME_BITS = 11;

  typedef enum logic {
    IDLE  = 1'b0,
    BREAK = 1'b1
  } trk_state_e;

endpackage

// File: rtl/ps2_fifo.sv
// Synchronous FIFO for received scan codes.
// Latency: a push is visible on head_dat/empty one cycle later; head_dat is 0 when empty.
// Backpressure: push while full is dropped (full is judged before any same-cycle pop);
//   pop while empty is ignored.
// Ports: clk/rst, push/push_dat (write side), pop (read side),
//   head_dat (current head), full, empty.
module ps2_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_dat,
  input  logic          pop,
  output logic [DW-1:0] head_dat,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic          do_wr;
  logic          do_rd;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_wr    = push && !full;
    do_rd    = pop && !empty;
    wr_ptr_d = do_wr ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    head_dat = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
    end
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: deserialises frames, buffers scan codes, tracks the held key.
// Latency: push one cycle after the completing falling edge; data/valid and tracker
//   outputs update one cycle after that.
// Backpressure: none toward the keyboard; frames arriving while the FIFO is full are
//   dropped and set sticky overflow (the tracker still sees them).
// Ports: clk/rst (async active-high), ps2_clk/ps2_data (async keyboard pins),
//   rd_en (pop), data/valid (FIFO head), overflow, cur_code/key_pressed/key_cnt (tracker).
// Build option: define PS2_PARITY_CHECK_EN to also require odd parity over bits 1-9.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd_en,
  output logic [7:0] data,
  output logic       valid,
  output logic       overflow,
  output logic [7:0] cur_code,
  output logic       key_pressed,
  output logic [7:0] key_cnt
);

  // Synchronisers: index 0 is the newest stage.
  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;

  // Frame assembly: shift_q holds bits already received, bit 0 at the LSB after 10 shifts.
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [9:0]  shift_q, shift_d;
  logic [10:0] frame;
  logic        fall_edge;
  logic        frame_done;
  logic        frame_ok;
  logic        acc_q, acc_d;
  logic [7:0]  code_q, code_d;

  // Tracker and status.
  trk_state_e  state_q, state_d;
  logic [7:0]  cur_code_q, cur_code_d;
  logic        key_pressed_q, key_pressed_d;
  logic [7:0]  key_cnt_q, key_cnt_d;
  logic        overflow_q, overflow_d;

  logic        fifo_full;
  logic        fifo_empty;

`ifndef PS2_PARITY_CHECK_EN
  logic        parity_unused;
  assign parity_unused = frame[9];
`endif

  always_comb begin
    clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], ps2_data};

    fall_edge  = clk_sync_q[SYNC_STAGES-1] & ~clk_sync_q[SYNC_STAGES-2];
    // Data is sampled from the oldest stage; it is stable across the falling edge.
    frame      = {dat_sync_q[SYNC_STAGES-1], shift_q};
    frame_done = fall_edge && (bit_cnt_q == 4'(FRAME_BITS - 1));

`ifdef PS2_PARITY_CHECK_EN
    frame_ok   = ~frame[0] & frame[10] & (^frame[9:1]);
`else
    frame_ok   = ~frame[0] & frame[10];
`endif

    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    if (fall_edge) begin
      shift_d   = frame[10:1];
      bit_cnt_d = frame_done ? 4'd0 : bit_cnt_q + 4'd1;
    end

    acc_d  = frame_done && frame_ok;
    code_d = frame_done ? frame[8:1] : code_q;

    overflow_d = overflow_q | (acc_q & fifo_full);

    state_d       = state_q;
    cur_code_d    = cur_code_q;
    key_pressed_d = key_pressed_q;
    key_cnt_d     = key_cnt_q;
    if (acc_q) begin
      case (state_q)
        IDLE: begin
          if (code_q == BREAK_CODE) begin
            state_d = BREAK;
          end else if (code_q == EXT_CODE) begin
            state_d = IDLE;
          end else if (!key_pressed_q || (code_q != cur_code_q)) begin
            cur_code_d    = code_q;
            key_pressed_d = 1'b1;
            key_cnt_d     = key_cnt_q + 8'd1;
          end
        end
        BREAK: begin
          cur_code_d    = 8'h00;
          key_pressed_d = 1'b0;
          state_d       = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q    <= '1;
      dat_sync_q    <= '1;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      acc_q         <= 1'b0;
      code_q        <= '0;
      overflow_q    <= 1'b0;
      state_q       <= IDLE;
      cur_code_q    <= '0;
      key_pressed_q <= 1'b0;
      key_cnt_q     <= '0;
    end else begin
      clk_sync_q    <= clk_sync_d;
      dat_sync_q    <= dat_sync_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      acc_q         <= acc_d;
      code_q        <= code_d;
      overflow_q    <= overflow_d;
      state_q       <= state_d;
      cur_code_q    <= cur_code_d;
      key_pressed_q <= key_pressed_d;
      key_cnt_q     <= key_cnt_d;
    end
  end

  ps2_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (8)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (acc_q),
    .push_dat (code_q),
    .pop      (rd_en),
    .head_dat (data),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign valid       = ~fifo_empty;
  assign overflow    = overflow_q;
  assign cur_code    = cur_code_q;
  assign key_pressed = key_pressed_q;
  assign key_cnt     = key_cnt_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx: directed scenarios plus randomized frames,
// compared every quiet cycle against a queue-based model of the keyboard receiver.
module tb_ps2_kbd_rx;

  localparam int DEPTH = 8;
  localparam int SYNC  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       overflow;
  logic [7:0] cur_code;
  logic       key_pressed;
  logic [7:0] key_cnt;

  ps2_kbd_rx #(
    .FIFO_DEPTH  (DEPTH),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .rd_en       (rd_en),
    .data        (data),
    .valid       (valid),
    .overflow    (overflow),
    .cur_code    (cur_code),
    .key_pressed (key_pressed),
    .key_cnt     (key_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Model state
  logic [7:0] mq[$];
  bit         m_ovf;
  bit         m_kp;
  bit         m_brk;
  logic [7:0] m_cur;
  logic [7:0] m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_outs();
    return {5'd0, valid, data, overflow, cur_code, key_pressed, key_cnt};
  endfunction

  function automatic logic [31:0] model_outs();
    logic [7:0] h;
    h = (mq.size() > 0) ? mq[0] : 8'h00;
    return {5'd0, mq.size() > 0, h, m_ovf, m_cur, m_kp, m_cnt};
  endfunction

  always @(negedge clk) begin
    if (chk_en) check("outs", dut_outs(), model_outs());
  end

  task automatic model_reset();
    mq.delete();
    m_ovf = 0; m_kp = 0; m_brk = 0; m_cur = 8'h00; m_cnt = 8'h00;
  endtask

  // Apply the receiver's rules to one complete 11-bit frame.
  task automatic model_frame(input logic [10:0] f, input bit pop_sync);
    bit         acc;
    bit         was_valid;
    logic [7:0] c;
    c   = f[8:1];
    acc = (f[0] == 1'b0) && (f[10] == 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    acc = acc && ((^f[9:1]) == 1'b1);
`endif
    was_valid = (mq.size() > 0);
    if (acc) begin
      if (mq.size() == DEPTH) m_ovf = 1;
      else mq.push_back(c);
      if (m_brk) begin
        m_cur = 8'h00; m_kp = 0; m_brk = 0;
      end else if (c == 8'hF0) begin
        m_brk = 1;
      end else if (c == 8'hE0) begin
        m_brk = 0;
      end else if (!(m_kp && c == m_cur)) begin
        m_cur = c; m_kp = 1; m_cnt = m_cnt + 8'd1;
      end
    end
    if (pop_sync && was_valid) void'(mq.pop_front());
  endtask

  // All tasks below are entered 1 time unit after a rising clk edge.
  task automatic reset_dut();
    rst = 1'b1;
    rd_en = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    model_reset();
    @(posedge clk); #1;
    check("rst_outs", dut_outs(), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Each bit: data set during the high phase, 4 cycles low, 4 cycles high.
  // pop_sync raises rd_en for exactly the cycle in which the frame is pushed.
  task automatic send_bits(input logic [10:0] f, input int n, input bit pop_sync);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      @(posedge clk); #1;
      if (i == 10) chk_en = 1'b0;
      ps2_clk = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        @(posedge clk); #1;
        rd_en = pop_sync && (i == 10) && (k == SYNC);
      end
      ps2_clk = 1'b1;
      repeat (3) begin
        @(posedge clk); #1;
      end
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] c, input bit bad_start,
                                           input bit bad_stop, input bit bad_par);
    logic par;
    par = (~^c) ^ bad_par;
    return {~bad_stop, par, c, bad_start};
  endfunction

  task automatic send_frame(input logic [7:0] c, input bit bad_start, input bit bad_stop,
                            input bit bad_par, input bit pop_sync);
    logic [10:0] f;
    f = mk_frame(c, bad_start, bad_stop, bad_par);
    send_bits(f, 11, pop_sync);
    @(posedge clk); #1;
    model_frame(f, pop_sync);
    chk_en = 1'b1;
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
    if (mq.size() > 0) void'(mq.pop_front());
  endtask

  task automatic expect_pop(input string name, input logic [7:0] exp);
    check(name, {31'd0, valid}, 32'd1);
    check(name, {24'd0, data}, {24'd0, exp});
    pop_one();
  endtask

  logic [7:0] seq2 [5];
  logic [7:0] rc;
  logic [7:0] last_c;

  initial begin
    seq2[0] = 8'h1C; seq2[1] = 8'h1C; seq2[2] = 8'h1C; seq2[3] = 8'hF0; seq2[4] = 8'h1C;
    model_reset();
    @(posedge clk); #1;
    reset_dut();
    chk_en = 1'b1;

    // Single valid frame 0x1C
    send_frame(8'h1C, 0, 0, 0, 0);
    check("t1_valid", {31'd0, valid}, 32'd1);
    check("t1_data", {24'd0, data}, 32'h1C);
    check("t1_cur", {24'd0, cur_code}, 32'h1C);
    check("t1_kp", {31'd0, key_pressed}, 32'd1);
    check("t1_cnt", {24'd0, key_cnt}, 32'd1);
    pop_one();
    check("t1_valid_after_pop", {31'd0, valid}, 32'd0);
    check("t1_data_after_pop", {24'd0, data}, 32'h0);

    // Auto-repeat then release
    reset_dut();
    for (int i = 0; i < 5; i++) send_frame(seq2[i], 0, 0, 0, 0);
    check("t2_cnt", {24'd0, key_cnt}, 32'd1);
    check("t2_cur", {24'd0, cur_code}, 32'h0);
    check("t2_kp", {31'd0, key_pressed}, 32'd0);
    for (int i = 0; i < 5; i++) expect_pop("t2_pop", seq2[i]);
    check("t2_empty", {31'd0, valid}, 32'd0);

    // Overflow without pops
    reset_dut();
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0, 0, 0);
    check("t3_ovf", {31'd0, overflow}, 32'd1);
    for (int i = 1; i <= 8; i++) expect_pop("t3_pop", 8'(i));
    check("t3_empty", {31'd0, valid}, 32'd0);

    // Overflow with a pop in the same cycle as the 9th push
    reset_dut();
    for (int i = 1; i <= 8; i++) send_frame(8'(i), 0, 0, 0, 0);
    send_frame(8'h09, 0, 0, 0, 1);
    check("t3b_ovf", {31'd0, overflow}, 32'd1);
    for (int i = 2; i <= 8; i++) expect_pop("t3b_pop", 8'(i));
    check("t3b_empty", {31'd0, valid}, 32'd0);

    // Parity and framing errors
    reset_dut();
    send_frame(8'h1C, 0, 0, 1, 0);
`ifdef PS2_PARITY_CHECK_EN
    check("t4_par_cnt", {24'd0, key_cnt}, 32'd0);
    check("t4_par_valid", {31'd0, valid}, 32'd0);
`else
    check("t4_par_cnt", {24'd0, key_cnt}, 32'd1);
    check("t4_par_valid", {31'd0, valid}, 32'd1);
`endif
    rc = key_cnt;
    send_frame(8'h32, 1, 0, 0, 0);
    check("t4_start_cnt", {24'd0, key_cnt}, {24'd0, rc});
    send_frame(8'h32, 0, 1, 0, 0);
    check("t4_stop_cnt", {24'd0, key_cnt}, {24'd0, rc});

    // Reset in the middle of a frame
    reset_dut();
    send_bits(mk_frame(8'h55, 0, 0, 0), 5, 0);
    reset_dut();
    send_frame(8'h32, 0, 0, 0, 0);
    check("t5_cnt", {24'd0, key_cnt}, 32'd1);
    check("t5_cur", {24'd0, cur_code}, 32'h32);
    check("t5_data", {24'd0, data}, 32'h32);

    // Randomized frames, errors and pops
    reset_dut();
    last_c = 8'h1C;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0:       rc = 8'hF0;
        1:       rc = 8'hE0;
        2, 3:    rc = last_c;
        default: rc = 8'($urandom_range(0, 255));
      endcase
      if (rc != 8'hF0 && rc != 8'hE0) last_c = rc;
      send_frame(rc, $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
      for (int p = $urandom_range(0, 2); p > 0; p--) pop_one();
    end

    // 256 press/release pairs: key_cnt wraps
    reset_dut();
    for (int i = 0; i < 256; i++) begin
      rc = (i % 2 == 0) ? 8'h1C : 8'h32;
      send_frame(rc, 0, 0, 0, 0);
      if (i == 254) check("t6_cnt255", {24'd0, key_cnt}, 32'd255);
      send_frame(8'hF0, 0, 0, 0, 0);
      send_frame(rc, 0, 0, 0, 0);
    end
    check("t6_wrap", {24'd0, key_cnt}, 32'd0);
    check("t6_kp", {31'd0, key_pressed}, 32'd0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
